// File: rtl/clock_reset_sequencer.sv
// Clock/reset/run sequencer: divided domain clocks, timed core reset,
// run-cycle counter with limit, abort and restart.
module clock_reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int DIV_W       = 4,
    parameter int RESET_HOLD  = 2,
    parameter int RUN_W       = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_DOMAINS*DIV_W-1:0] div_cfg,
    input  logic [RUN_W-1:0]             run_limit,
    output logic [NUM_DOMAINS-1:0]       domain_clk,
    output logic                         sys_reset,
    output logic                         running,
    output logic                         done,
    output logic [RUN_W-1:0]             cycle_count
);

    localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic [HOLD_W-1:0]            r_hold;
    logic [NUM_DOMAINS*DIV_W-1:0] r_div;
    logic [RUN_W-1:0]             r_limit;
    logic [DIV_W-1:0]             r_dcnt [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0]       r_dclk;
    logic                         r_sys_reset;
    logic                         r_running;
    logic                         r_done;
    logic [RUN_W-1:0]             r_cycle;

    logic [RUN_W-1:0]             w_next;
    logic                         w_hit;

    assign w_next = r_cycle + RUN_W'(1);
    assign w_hit  = (r_limit != '0) && (w_next == r_limit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_div       <= '0;
            r_limit     <= '0;
            r_dclk      <= '0;
            r_sys_reset <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_cycle     <= '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            // Domain dividers free-run through HOLD and RUN; DONE entry below overrides.
            if (r_state == S_HOLD || r_state == S_RUN) begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    if (r_dcnt[i] == r_div[i*DIV_W +: DIV_W]) begin
                        r_dcnt[i] <= '0;
                        r_dclk[i] <= ~r_dclk[i];
                    end else begin
                        r_dcnt[i] <= r_dcnt[i] + DIV_W'(1);
                    end
                end
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_HOLD;
                        r_div       <= div_cfg;
                        r_limit     <= run_limit;
                        r_sys_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_hold      <= '0;
                        r_cycle     <= '0;
                        r_dclk      <= '0;
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            r_dcnt[i] <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_sys_reset <= 1'b0;
                        r_running   <= 1'b1;
                        r_cycle     <= '0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (abort || w_hit) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_dclk    <= '0;
                        // A limit hit on the abort edge still reports the full limit.
                        r_cycle   <= w_hit ? w_next : r_cycle;
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            r_dcnt[i] <= '0;
                        end
                    end else begin
                        r_cycle <= w_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign domain_clk  = r_dclk;
    assign sys_reset   = r_sys_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign cycle_count = r_cycle;

endmodule
